// File: rtl/cpu_sequencer_pkg.sv
// Shared definitions for the multicycle sequencer:
// FSM states, instruction classes and opcode fields.
package cpu_sequencer_pkg;

   typedef enum logic [2:0] {
      S_START,
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_WB,
      S_MEM
   } state_t;

   typedef enum logic [2:0] {
      C_ALU,
      C_LOAD,
      C_STOR,
      C_JAL,
      C_JCOND,
      C_BCOND,
      C_ILL
   } iclass_t;

   localparam logic [3:0] OP_RTYPE = 4'h0;
   localparam logic [3:0] OP_ANDI  = 4'h1;
   localparam logic [3:0] OP_ORI   = 4'h2;
   localparam logic [3:0] OP_XORI  = 4'h3;
   localparam logic [3:0] OP_MEMJ  = 4'h4;
   localparam logic [3:0] OP_SHI   = 4'h8;
   localparam logic [3:0] OP_CMPI  = 4'hB;
   localparam logic [3:0] OP_BCOND = 4'hC;
   localparam logic [3:0] OP_BAD   = 4'hE;
   localparam logic [3:0] OP_LUI   = 4'hF;

   localparam logic [3:0] FN_LOAD  = 4'h0;
   localparam logic [3:0] FN_STOR  = 4'h4;
   localparam logic [3:0] FN_JAL   = 4'h8;
   localparam logic [3:0] FN_CMP   = 4'hB;
   localparam logic [3:0] FN_JCOND = 4'hC;

   // Logical immediates and LUI take IR[7:0] unsigned.
   function automatic logic imm_is_zx(input logic [3:0] op);
      return (op == OP_ANDI) || (op == OP_ORI) ||
             (op == OP_XORI) || (op == OP_LUI);
   endfunction

endpackage

// File: rtl/cpu_sequencer_decode.sv
// Combinational instruction decoder.
// ir in -> cls (class), imm (extended), wb_en, illegal.
module cpu_sequencer_decode
   import cpu_sequencer_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic [15:0]      ir,
   output iclass_t          cls,
   output logic [WIDTH-1:0] imm,
   output logic             wb_en,
   output logic             illegal
);

   logic [3:0] op;
   logic [3:0] fn;
   logic       is_mj;
   logic       mj_ok;

   assign op    = ir[15:12];
   assign fn    = ir[7:4];
   assign is_mj = (op == OP_MEMJ);
   assign mj_ok = (fn == FN_LOAD) || (fn == FN_STOR) ||
                  (fn == FN_JAL)  || (fn == FN_JCOND);

   always_comb begin
      cls = C_ALU;
      unique case (1'b1)
         is_mj && fn == FN_LOAD:  cls = C_LOAD;
         is_mj && fn == FN_STOR:  cls = C_STOR;
         is_mj && fn == FN_JAL:   cls = C_JAL;
         is_mj && fn == FN_JCOND: cls = C_JCOND;
         is_mj && !mj_ok:         cls = C_ILL;
         op == OP_BCOND:          cls = C_BCOND;
         op == OP_BAD:            cls = C_ILL;
         default: ;
      endcase
   end

   always_comb begin
      imm = {{(WIDTH-8){ir[7]}}, ir[7:0]};
      unique case (1'b1)
         imm_is_zx(op):
            imm = {{(WIDTH-8){1'b0}}, ir[7:0]};
         op == OP_SHI:
            imm = {{(WIDTH-5){ir[4]}}, ir[4:0]};
         default: ;
      endcase
   end

   // Compares only update flags.
   assign wb_en = !((op == OP_RTYPE && fn == FN_CMP) ||
                    op == OP_CMPI);
   assign illegal = (cls == C_ILL);

endmodule

// File: rtl/cpu_sequencer.sv
// Multicycle sequencer: owns PC/IR, fetches, decodes and
// steers regfile, ALU, memory and PSR write enables.
// Ports: mem_* req/ready memory port; rf_* regfile read/write;
//   alu_* operands/controls and result/flag enables in;
//   psr_we gated flag enables; pc current PC; illegal pulse.
module cpu_sequencer
   import cpu_sequencer_pkg::*;
#(
   parameter int               WIDTH    = 16,
   parameter logic [WIDTH-1:0] RESET_PC = '0
) (
   input  logic             clk,
   input  logic             reset,
   output logic             mem_req,
   output logic             mem_we,
   output logic [WIDTH-1:0] mem_addr,
   output logic [WIDTH-1:0] mem_wdata,
   input  logic [WIDTH-1:0] mem_rdata,
   input  logic             mem_ready,
   output logic [3:0]       rf_raddr_dst,
   input  logic [WIDTH-1:0] rf_rdata_dst,
   output logic [3:0]       rf_raddr_src,
   input  logic [WIDTH-1:0] rf_rdata_src,
   output logic             rf_we,
   output logic [3:0]       rf_waddr,
   output logic [WIDTH-1:0] rf_wdata,
   output logic [WIDTH-1:0] alu_dst,
   output logic [WIDTH-1:0] alu_src,
   output logic [3:0]       alu_oper,
   output logic [3:0]       alu_func,
   output logic [3:0]       alu_cond,
   input  logic [WIDTH-1:0] alu_result,
   input  logic [4:0]       alu_psr_wren,
   output logic [4:0]       psr_we,
   output logic [WIDTH-1:0] pc,
   output logic             illegal
);

   state_t           state, nxt;
   logic [WIDTH-1:0] ir, a, b, imm_q, res;
   logic [WIDTH-1:0] pc_nxt, pc_one, imm;
   logic [4:0]       psr_q;
   iclass_t          cls;
   logic             wb_en, dec_ill;

   cpu_sequencer_decode #(.WIDTH(WIDTH)) u_dec (
      .ir      (ir[15:0]),
      .cls     (cls),
      .imm     (imm),
      .wb_en   (wb_en),
      .illegal (dec_ill)
   );

   assign pc_one = pc + WIDTH'(1);

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_START;
         pc    <= RESET_PC;
         ir    <= '0;
         a     <= '0;
         b     <= '0;
         imm_q <= '0;
         res   <= '0;
         psr_q <= '0;
      end else begin
         state <= nxt;
         pc    <= pc_nxt;
         if (state == S_FETCH && mem_ready)
            ir <= mem_rdata;
         if (state == S_DECODE) begin
            a     <= rf_rdata_dst;
            b     <= rf_rdata_src;
            imm_q <= imm;
         end
         // Flags are captured here and committed only in WB.
         if (state == S_EXEC) begin
            res   <= alu_result;
            psr_q <= alu_psr_wren;
         end
      end
   end

   always_comb begin
      nxt          = state;
      pc_nxt       = pc;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr     = '0;
      mem_wdata    = '0;
      rf_we        = 1'b0;
      rf_waddr     = ir[11:8];
      rf_wdata     = '0;
      alu_dst      = '0;
      alu_src      = '0;
      psr_we       = '0;
      illegal      = 1'b0;
      rf_raddr_dst = ir[11:8];
      rf_raddr_src = ir[3:0];
      alu_oper     = ir[15:12];
      alu_func     = ir[7:4];
      alu_cond     = ir[11:8];
      unique case (state)
         S_START: begin
            rf_waddr     = '0;
            rf_raddr_dst = '0;
            rf_raddr_src = '0;
            alu_oper     = '0;
            alu_func     = '0;
            alu_cond     = '0;
            nxt          = S_FETCH;
         end
         S_FETCH: begin
            mem_req  = 1'b1;
            mem_addr = pc;
            if (mem_ready) nxt = S_DECODE;
         end
         S_DECODE: begin
            if (dec_ill) begin
               illegal = 1'b1;
               pc_nxt  = pc_one;
               nxt     = S_FETCH;
            end else if (cls == C_LOAD || cls == C_STOR) begin
               nxt = S_MEM;
            end else begin
               nxt = S_EXEC;
            end
         end
         S_EXEC: begin
            nxt = S_FETCH;
            unique case (cls)
               C_ALU: begin
                  alu_dst = a;
                  alu_src = (ir[15:12] == OP_RTYPE) ? b : imm_q;
                  nxt     = S_WB;
               end
               C_BCOND: begin
                  alu_dst = pc_one;
                  alu_src = imm_q;
                  pc_nxt  = alu_result;
               end
               C_JCOND: begin
                  alu_dst = pc_one;
                  alu_src = b;
                  pc_nxt  = alu_result;
               end
               // Target comes from latched b, so a link
               // register equal to the target is safe.
               C_JAL: begin
                  alu_dst  = a;
                  alu_src  = pc_one;
                  rf_we    = 1'b1;
                  rf_wdata = alu_result;
                  pc_nxt   = b;
               end
               default: ;
            endcase
         end
         S_WB: begin
            rf_we    = wb_en;
            rf_wdata = res;
            psr_we   = psr_q;
            pc_nxt   = pc_one;
            nxt      = S_FETCH;
         end
         S_MEM: begin
            mem_req   = 1'b1;
            mem_addr  = b;
            mem_we    = (cls == C_STOR);
            mem_wdata = a;
            if (mem_ready) begin
               rf_we    = (cls == C_LOAD);
               rf_wdata = mem_rdata;
               pc_nxt   = pc_one;
               nxt      = S_FETCH;
            end
         end
         default: nxt = S_START;
      endcase
   end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: directed program,
// behavioural memory/regfile/ALU, event monitor.
module tb_cpu_sequencer;

   typedef struct {
      int          k;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] c;
   } ev_t;

   localparam int E_MEM = 0;
   localparam int E_RF  = 1;
   localparam int E_PSR = 2;
   localparam int E_ILL = 3;

   logic        clk, reset;
   logic        mem_req, mem_we, mem_ready;
   logic [15:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  rf_raddr_dst, rf_raddr_src, rf_waddr;
   logic [15:0] rf_rdata_dst, rf_rdata_src, rf_wdata;
   logic        rf_we, illegal;
   logic [15:0] alu_dst, alu_src, alu_result, pc;
   logic [3:0]  alu_oper, alu_func, alu_cond;
   logic [4:0]  alu_psr_wren, psr_we;

   logic [15:0] mem [0:65535];
   logic [15:0] rf  [0:15];
   int          wcnt;
   int          total, bad;
   ev_t         exp_q[$];

   cpu_sequencer dut (
      .clk          (clk),
      .reset        (reset),
      .mem_req      (mem_req),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata),
      .mem_ready    (mem_ready),
      .rf_raddr_dst (rf_raddr_dst),
      .rf_rdata_dst (rf_rdata_dst),
      .rf_raddr_src (rf_raddr_src),
      .rf_rdata_src (rf_rdata_src),
      .rf_we        (rf_we),
      .rf_waddr     (rf_waddr),
      .rf_wdata     (rf_wdata),
      .alu_dst      (alu_dst),
      .alu_src      (alu_src),
      .alu_oper     (alu_oper),
      .alu_func     (alu_func),
      .alu_cond     (alu_cond),
      .alu_result   (alu_result),
      .alu_psr_wren (alu_psr_wren),
      .psr_we       (psr_we),
      .pc           (pc),
      .illegal      (illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Wait states per address.
   function automatic int wait_of(input logic [15:0] ad);
      case (ad)
         16'h0001: return 3;
         16'h0040: return 2;
         16'h0077: return 1000;
         default:  return 0;
      endcase
   endfunction

   assign mem_rdata = mem[mem_addr];
   assign mem_ready = mem_req && (wcnt >= wait_of(mem_addr));

   always @(posedge clk) begin
      if (mem_req && !mem_ready) wcnt <= wcnt + 1;
      else wcnt <= 0;
      if (mem_req && mem_ready && mem_we)
         mem[mem_addr] <= mem_wdata;
      if (rf_we) rf[rf_waddr] <= rf_wdata;
   end

   assign rf_rdata_dst = rf[rf_raddr_dst];
   assign rf_rdata_src = rf[rf_raddr_src];

   // ALU stand-in: adder; cond 1 on a branch means not taken.
   logic br, nt;
   assign br = (alu_oper == 4'hC) ||
               (alu_oper == 4'h4 && alu_func == 4'hC);
   assign nt = br && (alu_cond == 4'd1);
   assign alu_result   = nt ? alu_dst : alu_dst + alu_src;
   assign alu_psr_wren = alu_dst[4:0] ^ alu_src[4:0] ^ 5'h15;

   task automatic push(input int k, input logic [15:0] a,
                       input logic [15:0] b, input logic [15:0] c);
      ev_t e;
      e.k = k; e.a = a; e.b = b; e.c = c;
      exp_q.push_back(e);
   endtask

   task automatic fetch(input logic [15:0] ad);
      push(E_MEM, 16'd0, ad, 16'd0);
   endtask

   task automatic chk(input int k, input logic [15:0] a,
                      input logic [15:0] b, input logic [15:0] c);
      ev_t e;
      total++;
      if (exp_q.size() == 0) begin
         bad++;
         $display("FAIL unexpected_event kind=%0d got %h %h %h need none",
                  k, a, b, c);
      end else begin
         e = exp_q.pop_front();
         if (e.k != k || e.a != a || e.b != b || e.c != c) begin
            bad++;
            $display("FAIL event got kind=%0d %h %h %h need kind=%0d %h %h %h",
                     k, a, b, c, e.k, e.a, e.b, e.c);
         end
      end
   endtask

   task automatic dchk(input string nm, input logic [15:0] got,
                       input logic [15:0] need);
      total++;
      if (got !== need) begin
         bad++;
         $display("FAIL %s got %h need %h", nm, got, need);
      end
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         if (mem_req && mem_ready)
            chk(E_MEM, {15'd0, mem_we}, mem_addr,
                mem_we ? mem_wdata : 16'd0);
         if (rf_we)
            chk(E_RF, {12'd0, rf_waddr}, rf_wdata, 16'd0);
         if (psr_we != 5'd0)
            chk(E_PSR, {11'd0, psr_we}, 16'd0, 16'd0);
         if (illegal)
            chk(E_ILL, 16'd0, 16'd0, 16'd0);
      end
   end

   initial begin
      bit hit;
      total = 0;
      bad   = 0;
      wcnt  = 0;
      reset = 1'b1;
      for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
      for (int i = 0; i < 16; i++) rf[i] = 16'h0000;
      rf[1] = 16'h0003;  rf[2]  = 16'h0005;
      rf[4] = 16'h0010;  rf[5]  = 16'h1234;
      rf[6] = 16'h0040;  rf[7]  = 16'h001C;
      rf[8] = 16'h0050;  rf[9]  = 16'h0001;
      rf[10] = 16'h0020; rf[11] = 16'h0002;
      rf[13] = 16'hFFA5; rf[14] = 16'h0077;
      mem[16'h0010] = 16'hBEEF;

      mem[16'h0000] = 16'h0152; fetch(16'h0000);
      push(E_RF, 16'd1, 16'h0008, 16'd0);
      push(E_PSR, 16'h13, 16'd0, 16'd0);
      mem[16'h0001] = 16'h4304; fetch(16'h0001);
      push(E_MEM, 16'd0, 16'h0010, 16'd0);
      push(E_RF, 16'd3, 16'hBEEF, 16'd0);
      mem[16'h0002] = 16'h4546; fetch(16'h0002);
      push(E_MEM, 16'd1, 16'h0040, 16'h1234);
      mem[16'h0003] = 16'h40C7; fetch(16'h0003);
      mem[16'h0020] = 16'hC0FE; fetch(16'h0020);
      mem[16'h001F] = 16'h4888; fetch(16'h001F);
      push(E_RF, 16'd8, 16'h0070, 16'd0);
      mem[16'h0050] = 16'hC1FE; fetch(16'h0050);
      mem[16'h0051] = 16'h4F11; fetch(16'h0051);
      push(E_ILL, 16'd0, 16'd0, 16'd0);
      mem[16'h0052] = 16'hE000; fetch(16'h0052);
      push(E_ILL, 16'd0, 16'd0, 16'd0);
      mem[16'h0053] = 16'h01B2; fetch(16'h0053);
      push(E_PSR, 16'h18, 16'd0, 16'd0);
      mem[16'h0054] = 16'h1980; fetch(16'h0054);
      push(E_RF, 16'd9, 16'h0081, 16'd0);
      push(E_PSR, 16'h14, 16'd0, 16'd0);
      mem[16'h0055] = 16'h5AF0; fetch(16'h0055);
      push(E_RF, 16'd10, 16'h0010, 16'd0);
      push(E_PSR, 16'h05, 16'd0, 16'd0);
      mem[16'h0056] = 16'h8B1F; fetch(16'h0056);
      push(E_RF, 16'd11, 16'h0001, 16'd0);
      push(E_PSR, 16'h08, 16'd0, 16'd0);
      mem[16'h0057] = 16'hFCAB; fetch(16'h0057);
      push(E_RF, 16'd12, 16'h00AB, 16'd0);
      push(E_PSR, 16'h1E, 16'd0, 16'd0);
      mem[16'h0058] = 16'hB103; fetch(16'h0058);
      push(E_PSR, 16'h1E, 16'd0, 16'd0);
      mem[16'h0059] = 16'h40CD; fetch(16'h0059);
      mem[16'hFFFF] = 16'hC005; fetch(16'hFFFF);
      mem[16'h0005] = 16'h430E; fetch(16'h0005);

      repeat (3) @(posedge clk);
      @(negedge clk);
      dchk("rst_req", {15'd0, mem_req}, 16'd0);
      dchk("rst_pc", pc, 16'h0000);
      dchk("rst_rfwe", {15'd0, rf_we}, 16'd0);
      dchk("rst_psr", {11'd0, psr_we}, 16'd0);
      dchk("rst_aludst", alu_dst, 16'd0);
      dchk("rst_oper", {12'd0, alu_oper}, 16'd0);
      reset = 1'b0;

      @(negedge clk);
      dchk("c1_req", {15'd0, mem_req}, 16'd1);
      dchk("c1_addr", mem_addr, 16'h0000);
      repeat (3) @(negedge clk);
      dchk("c4_rfwe", {15'd0, rf_we}, 16'd1);
      dchk("c4_psr", {11'd0, psr_we}, 16'h0013);

      hit = 0;
      for (int i = 0; i < 50 && !hit; i++) begin
         @(negedge clk);
         hit = mem_req && mem_addr == 16'h0001;
      end
      dchk("stall_seen", {15'd0, hit}, 16'd1);
      for (int i = 0; i < 3; i++) begin
         dchk("stall_rdy", {15'd0, mem_ready}, 16'd0);
         dchk("stall_req", {15'd0, mem_req}, 16'd1);
         dchk("stall_addr", mem_addr, 16'h0001);
         dchk("stall_pc", pc, 16'h0001);
         @(negedge clk);
      end

      hit = 0;
      for (int i = 0; i < 200 && !hit; i++) begin
         @(negedge clk);
         hit = mem_req && mem_ready && mem_addr == 16'h0020;
      end
      dchk("bc_seen", {15'd0, hit}, 16'd1);
      repeat (2) @(negedge clk);
      dchk("bc_dst", alu_dst, 16'h0021);
      dchk("bc_src", alu_src, 16'hFFFE);

      hit = 0;
      for (int i = 0; i < 400 && !hit; i++) begin
         @(negedge clk);
         hit = mem_req && mem_addr == 16'h0077;
      end
      dchk("mw_seen", {15'd0, hit}, 16'd1);
      repeat (2) @(negedge clk);
      dchk("mw_hold", {15'd0, mem_req}, 16'd1);
      reset = 1'b1;
      @(negedge clk);
      dchk("mw_req", {15'd0, mem_req}, 16'd0);
      dchk("mw_pc", pc, 16'h0000);
      dchk("mw_rfwe", {15'd0, rf_we}, 16'd0);
      repeat (3) @(negedge clk);
      dchk("q_left", 16'(exp_q.size()), 16'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
